// File: rtl/synth_pkg.sv
// Shared types for the synth voice path: allocator FSM states and note index type.
package synth_pkg;

  localparam int unsigned NOTE_W_DEFAULT = 4;

  typedef logic [NOTE_W_DEFAULT-1:0] note_t;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StCommit
  } alloc_state_t;

endpackage

// File: rtl/voice_lru.sv
// Least-recently-allocated tracker: one rank per slot, rank NUM_VOICES-1 is the oldest.
// Ranks always form a permutation of 0..NUM_VOICES-1.
module voice_lru #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  output logic [IDX_W-1:0] oldest_idx
);

  logic [IDX_W-1:0] rank_q [NUM_VOICES];
  logic [IDX_W-1:0] rank_d [NUM_VOICES];

  // Rank registers; reset to identity ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        rank_q[v] <= IDX_W'(v);
      end
    end else begin
      rank_q <= rank_d;
    end
  end

  // Touched slot becomes newest; slots that were newer than it age by one.
  always_comb begin
    rank_d = rank_q;
    if (touch) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        if (rank_q[v] < rank_q[touch_idx]) begin
          rank_d[v] = rank_q[v] + 1'b1;
        end
      end
      rank_d[touch_idx] = '0;
    end
  end

  // Find the slot holding the maximum rank.
  always_comb begin
    oldest_idx = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if (rank_q[v] == IDX_W'(NUM_VOICES - 1)) begin
        oldest_idx = IDX_W'(v);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: retrigger matching slot, else lowest free slot, else steal the
// least-recently-allocated slot. Each event takes IDLE -> LOOKUP -> COMMIT (3 cycles).
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_W     = NOTE_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_press,
  input  logic [NOTE_W-1:0]            ev_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic [7:0]                   steal_cnt
);

  localparam int unsigned IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [7:0]  STEAL_MAX = 8'hFF;

  alloc_state_t state_q, state_d;

  logic                  ev_press_q;
  logic [NOTE_W-1:0]     ev_note_q;

  logic [NUM_VOICES-1:0] match_q, match_d;
  logic                  free_found_q, free_found_d;
  logic [IDX_W-1:0]      free_idx_q, free_idx_d;
  logic [IDX_W-1:0]      oldest_q, lru_oldest;

  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [NOTE_W-1:0]     note_d [NUM_VOICES];
  logic [7:0]            steal_q, steal_d;

  logic                  accept;
  logic                  match_found;
  logic [IDX_W-1:0]      match_idx;
  logic                  touch;
  logic [IDX_W-1:0]      target;

  assign ev_ready = (state_q == StIdle);
  assign accept   = ev_valid && ev_ready;

  voice_lru #(
    .NUM_VOICES (NUM_VOICES),
    .IDX_W      (IDX_W)
  ) u_lru (
    .clk        (clk),
    .rst        (rst),
    .touch      (touch),
    .touch_idx  (target),
    .oldest_idx (lru_oldest)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Fixed three-step sequence per accepted event.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ev_valid) state_d = StLookup;
      StLookup: state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Latch the event on accept and the lookup results in LOOKUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_press_q   <= 1'b0;
      ev_note_q    <= '0;
      match_q      <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      oldest_q     <= '0;
    end else begin
      if (accept) begin
        ev_press_q <= ev_press;
        ev_note_q  <= ev_note;
      end
      if (state_q == StLookup) begin
        match_q      <= match_d;
        free_found_q <= free_found_d;
        free_idx_q   <= free_idx_d;
        oldest_q     <= lru_oldest;
      end
    end
  end

  // Lookup: matching active slots and the lowest-index free slot.
  always_comb begin
    match_d      = '0;
    free_found_d = 1'b0;
    free_idx_d   = '0;
    for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
      match_d[v] = active_q[v] && (note_q[v] == ev_note_q);
      if (!active_q[v]) begin
        free_found_d = 1'b1;
        free_idx_d   = IDX_W'(v);
      end
    end
  end

  // Lowest matching slot from the registered match mask.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int v = int'(NUM_VOICES) - 1; v >= 0; v--) begin
      if (match_q[v]) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(v);
      end
    end
  end

  // Commit: pick target and compute next voice state.
  always_comb begin
    active_d = active_q;
    note_d   = note_q;
    trig_d   = '0;
    steal_d  = steal_q;
    touch    = 1'b0;
    target   = '0;
    if (state_q == StCommit) begin
      if (ev_press_q) begin
        if (match_found) begin
          target = match_idx;
        end else if (free_found_q) begin
          target = free_idx_q;
        end else begin
          target = oldest_q;
          if (steal_q != STEAL_MAX) begin
            steal_d = steal_q + 8'd1;
          end
        end
        active_d[target] = 1'b1;
        note_d[target]   = ev_note_q;
        trig_d[target]   = 1'b1;
        touch            = 1'b1;
      end else begin
        // Release keeps note values so envelopes can finish on the last pitch.
        active_d = active_q & ~match_q;
      end
    end
  end

  // Voice registers; trig self-clears so it is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
      trig_q   <= '0;
      steal_q  <= '0;
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        note_q[v] <= '0;
      end
    end else begin
      active_q <= active_d;
      trig_q   <= trig_d;
      steal_q  <= steal_d;
      note_q   <= note_d;
    end
  end

  // Flatten per-slot notes onto the output bus.
  always_comb begin
    voice_note = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
    end
  end

  assign voice_active = active_q;
  assign voice_trig   = trig_q;
  assign steal_cnt    = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with default parameters (4 voices, 4-bit notes).
module tb_voice_allocator;

  logic        tb_clk = 1'b0;
  logic        rst;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_press;
  logic [3:0]  ev_note;
  logic [3:0]  voice_active;
  logic [15:0] voice_note;
  logic [3:0]  voice_trig;
  logic [7:0]  steal_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        press;
    logic [3:0]  note;
    logic [3:0]  active;
    logic [3:0]  trig;
    logic [15:0] notes;
    logic [7:0]  steal;
  } vec_t;

  vec_t vecs [11];

  voice_allocator #(
    .NUM_VOICES (4),
    .NOTE_W     (4)
  ) dut (
    .clk          (tb_clk),
    .rst          (rst),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_press     (ev_press),
    .ev_note      (ev_note),
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .voice_trig   (voice_trig),
    .steal_cnt    (steal_cnt)
  );

  always #50 tb_clk = ~tb_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for ev_ready.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ev_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge tb_clk);
    end
  endtask

  task automatic do_event(input string tag, input logic press, input logic [3:0] note,
                          input logic [3:0] exp_active, input logic [3:0] exp_trig,
                          input logic [15:0] exp_notes, input logic [7:0] exp_steal);
    bit ok;
    @(negedge tb_clk);
    wait_ready(ok);
    chk({tag, " ready_before"}, 32'(ok), 32'd1);
    ev_valid = 1'b1;
    ev_press = press;
    ev_note  = note;
    @(posedge tb_clk);  // accept edge N
    #1;
    ev_valid = 1'b0;
    chk({tag, " ready_low_n"}, 32'(ev_ready), 32'd0);
    @(posedge tb_clk);
    #1;
    chk({tag, " trig_early"}, 32'(voice_trig), 32'd0);
    @(posedge tb_clk);  // N+2
    #1;
    chk({tag, " active"}, 32'(voice_active), 32'(exp_active));
    chk({tag, " trig"}, 32'(voice_trig), 32'(exp_trig));
    chk({tag, " notes"}, 32'(voice_note), 32'(exp_notes));
    chk({tag, " steal"}, 32'(steal_cnt), 32'(exp_steal));
    chk({tag, " ready_back"}, 32'(ev_ready), 32'd1);
    @(posedge tb_clk);
    #1;
    chk({tag, " trig_clear"}, 32'(voice_trig), 32'd0);
  endtask

  initial begin
    int n;
    int cyc;
    int last;
    int bad_gaps;
    int trig_seen;

    //          press note  active   trig     notes     steal
    vecs[0]  = '{1'b1, 4'd3,  4'b0001, 4'b0001, 16'h0003, 8'd0};
    vecs[1]  = '{1'b1, 4'd5,  4'b0011, 4'b0010, 16'h0053, 8'd0};
    vecs[2]  = '{1'b1, 4'd7,  4'b0111, 4'b0100, 16'h0753, 8'd0};
    vecs[3]  = '{1'b1, 4'd3,  4'b0111, 4'b0001, 16'h0753, 8'd0};  // retrigger slot 0
    vecs[4]  = '{1'b1, 4'd9,  4'b1111, 4'b1000, 16'h9753, 8'd0};
    vecs[5]  = '{1'b1, 4'd11, 4'b1111, 4'b0010, 16'h97B3, 8'd1};  // steal slot 1 (note 5)
    vecs[6]  = '{1'b0, 4'd7,  4'b1011, 4'b0000, 16'h97B3, 8'd1};  // release keeps note
    vecs[7]  = '{1'b0, 4'd12, 4'b1011, 4'b0000, 16'h97B3, 8'd1};  // release no-op
    vecs[8]  = '{1'b1, 4'd12, 4'b1111, 4'b0100, 16'h9CB3, 8'd1};  // free slot 2
    vecs[9]  = '{1'b0, 4'd3,  4'b1110, 4'b0000, 16'h9CB3, 8'd1};
    vecs[10] = '{1'b1, 4'd3,  4'b1111, 4'b0001, 16'h9CB3, 8'd1};  // free slot 0, no match

    rst      = 1'b1;
    ev_valid = 1'b0;
    ev_press = 1'b0;
    ev_note  = '0;
    repeat (2) @(posedge tb_clk);
    #1;
    chk("rst ready", 32'(ev_ready), 32'd1);
    chk("rst active", 32'(voice_active), 32'd0);
    chk("rst notes", 32'(voice_note), 32'd0);
    chk("rst trig", 32'(voice_trig), 32'd0);
    chk("rst steal", 32'(steal_cnt), 32'd0);
    @(negedge tb_clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_event($sformatf("vec%0d", i), vecs[i].press, vecs[i].note, vecs[i].active,
               vecs[i].trig, vecs[i].notes, vecs[i].steal);
    end

    // Reset asserted while the event is in COMMIT.
    @(negedge tb_clk);
    ev_valid = 1'b1;
    ev_press = 1'b1;
    ev_note  = 4'd5;
    @(posedge tb_clk);
    #1;
    ev_valid = 1'b0;
    @(posedge tb_clk);
    #20;
    rst = 1'b1;
    #1;
    chk("midrst ready", 32'(ev_ready), 32'd1);
    chk("midrst active", 32'(voice_active), 32'd0);
    chk("midrst notes", 32'(voice_note), 32'd0);
    chk("midrst trig", 32'(voice_trig), 32'd0);
    chk("midrst steal", 32'(steal_cnt), 32'd0);
    trig_seen = 0;
    @(posedge tb_clk);
    #1;
    if (voice_trig != 4'b0000) trig_seen++;
    @(negedge tb_clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge tb_clk);
      #1;
      if (voice_trig != 4'b0000) trig_seen++;
    end
    chk("midrst no_trig", 32'(trig_seen), 32'd0);
    chk("midrst active_after", 32'(voice_active), 32'd0);
    chk("midrst ready_after", 32'(ev_ready), 32'd1);

    // Fill the bank, then stream 300 distinct presses with ev_valid held high.
    do_event("fill0", 1'b1, 4'd0, 4'b0001, 4'b0001, 16'h0000, 8'd0);
    do_event("fill1", 1'b1, 4'd1, 4'b0011, 4'b0010, 16'h0010, 8'd0);
    do_event("fill2", 1'b1, 4'd2, 4'b0111, 4'b0100, 16'h0210, 8'd0);
    do_event("fill3", 1'b1, 4'd3, 4'b1111, 4'b1000, 16'h3210, 8'd0);

    n        = 0;
    cyc      = 0;
    last     = -1;
    bad_gaps = 0;
    ev_press = 1'b1;
    while (n < 300 && cyc < 2000) begin
      @(negedge tb_clk);
      cyc++;
      if (ev_ready) begin
        if (n == 100) chk("stream steal100", 32'(steal_cnt), 32'd100);
        if (n == 255) chk("stream steal255", 32'(steal_cnt), 32'd255);
        if (n == 299) chk("stream steal_sat", 32'(steal_cnt), 32'd255);
        if (last >= 0 && (cyc - last) != 3) bad_gaps++;
        last     = cyc;
        ev_note  = 4'((4 + n) % 16);
        ev_valid = 1'b1;
        n++;
      end
    end
    chk("stream accepts", 32'(n), 32'd300);
    chk("stream gaps", 32'(bad_gaps), 32'd0);
    @(posedge tb_clk);
    #1;
    ev_valid = 1'b0;
    repeat (3) @(posedge tb_clk);
    #1;
    chk("stream steal_final", 32'(steal_cnt), 32'd255);
    chk("stream active", 32'(voice_active), 32'hF);
    chk("stream ready", 32'(ev_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
